// File: rtl/fb_scanout.sv
`default_nettype none
// ==========================================================================
// fb_scanout : streams a ROW x ROW frame from shared image memory to a
//              valid/ready pixel consumer with SOL/EOF markers. Rev 1.0
// ==========================================================================
module fb_scanout #(
  parameter int AW    = 20,
  parameter int DW    = 24,
  parameter int ROW   = 256,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] fb_addr,
  output logic          mem_req,
  input  logic          mem_gnt,
  output logic [AW-1:0] im_a,
  output logic          im_oe,
  input  logic [DW-1:0] im_q,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_sol,
  output logic          pix_eof,
  output logic          busy,
  output logic          done
);

  localparam int NPIX = ROW * ROW;
  localparam int CW   = $clog2(NPIX) + 1;
  localparam int PW   = $clog2(DEPTH);

  localparam logic [CW-1:0] C_NPIX  = CW'(NPIX);
  localparam logic [CW-1:0] C_LAST  = CW'(NPIX - 1);
  localparam logic [CW-1:0] C_ROW   = CW'(ROW);
  localparam logic [PW:0]   C_DEPTH = (PW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] last_a_q, last_a_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [DW-1:0] fifo_mem_q [DEPTH];
  logic [DW-1:0] fifo_mem_d [DEPTH];

  logic          start_ok, issue, push, pop;
  logic [PW:0]   occ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)               state_d = S_FETCH;
      S_FETCH: if (rd_cnt_d == C_NPIX)  state_d = S_DRAIN;
      S_DRAIN: if (out_cnt_q == C_NPIX) state_d = S_IDLE;
      default:                          state_d = S_IDLE;
    endcase
  end

  // Occupancy counts the read still in flight so the FIFO can never overflow.
  always_comb begin
    mem_req   = (state_q == S_FETCH);
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DRAIN) && (out_cnt_q == C_NPIX);
    occ       = count_q + {{PW{1'b0}}, inflight_q};
    issue     = mem_req && mem_gnt && (occ < C_DEPTH) && (rd_cnt_q < C_NPIX);
    im_oe     = issue;
    im_a      = issue ? (base_q + AW'(rd_cnt_q)) : last_a_q;
    pix_valid = (count_q != '0);
    pix_data  = fifo_mem_q[rd_ptr_q];
    pix_sol   = pix_valid && ((out_cnt_q % C_ROW) == '0);
    pix_eof   = pix_valid && (out_cnt_q == C_LAST);
  end

  always_comb begin
    start_ok   = (state_q == S_IDLE) && start;
    push       = inflight_q;
    pop        = pix_valid && pix_ready;
    base_d     = start_ok ? fb_addr : base_q;
    inflight_d = issue;
    last_a_d   = issue ? im_a : last_a_q;
    rd_cnt_d   = rd_cnt_q;
    out_cnt_d  = out_cnt_q;
    if (start_ok) begin
      rd_cnt_d  = '0;
      out_cnt_d = '0;
    end else begin
      if (issue) rd_cnt_d  = rd_cnt_q + 1'b1;
      if (pop)   out_cnt_d = out_cnt_q + 1'b1;
    end
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = im_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q     <= '0;
      last_a_q   <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      fifo_mem_q <= '{default: '0};
    end else begin
      base_q     <= base_d;
      last_a_q   <= last_a_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      fifo_mem_q <= fifo_mem_d;
    end
  end

  always @(posedge clk) begin
    if (!reset) assert (!(push && !pop && (count_q == C_DEPTH)));
  end

endmodule
`default_nettype wire
